// File: rtl/dp_share_pkg.sv
// Shared definitions for the dp_share_arbiter slice.
//   DP_IN_W  : operand width presented to the shared datapath
//   DP_OUT_W : result width returned by the shared datapath
//   state_t  : arbiter sequencing states
//   idw(n)   : requester-index width, never narrower than one bit
package dp_share_pkg;

  localparam int DP_IN_W  = 4;
  localparam int DP_OUT_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dp_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req       : per-lane request mask
//   ptr       : lane with highest priority this cycle (always < N)
//   grant     : one-hot grant of the first requesting lane at or above ptr,
//               wrapping from N-1 to 0; all zero when nothing requests
//   idx       : encoded index of the granted lane (0 when none)
//   any_valid : at least one lane requests
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any_valid
);

  always_comb begin
    int lane;
    logic [IDW-1:0] sel;
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    lane      = 0;
    sel       = '0;
    // Walk N candidates starting at ptr; subtracting N once is enough
    // because ptr < N and k < N.
    for (int k = 0; k < N; k++) begin
      lane = int'(ptr) + k;
      if (lane >= N) lane = lane - N;
      sel = IDW'(lane);
      if (!any_valid && req[sel]) begin
        any_valid  = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/dp_share_arbiter.sv
// dp_share_arbiter: time-shares one external 4-in/12-out datapath between
// N_REQ requesters, round-robin, one operation in flight.
//
// Handshakes: a requester lane transfers when req_valid[i] && req_ready[i]
// at a rising edge; req_valid/req_data must hold until req_ready. A
// response transfers when resp_valid && resp_ready at a rising edge;
// resp_valid/resp_data/resp_id hold until then. resp_ready is ignored
// outside RESP.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req_valid   : per-lane operand valid
//   req_data    : operands, lane i at [4i+3:4i]
//   req_ready   : one-hot accept, only in IDLE
//   dp_in       : operand held on the shared datapath input
//   dp_out      : datapath result, sampled DP_LAT cycles after accept
//   resp_valid, resp_ready, resp_data, resp_id : result channel
//   busy        : registered, high in WAIT or RESP (state exposure)
//   perf_ops, perf_stall : only with macro DP_SHARE_PERF_EN defined;
//                 completed handshakes and RESP cycles without resp_ready
module dp_share_arbiter
  import dp_share_pkg::*;
#(
  parameter int  N_REQ  = 4,
  parameter int  DP_LAT = 0,
  localparam int IDW    = idw(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DP_IN_W-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DP_IN_W-1:0]         dp_in,
  input  logic [DP_OUT_W-1:0]        dp_out,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DP_OUT_W-1:0]        resp_data,
  output logic [IDW-1:0]             resp_id,
  output logic                       busy
`ifdef DP_SHARE_PERF_EN
  ,
  output logic [31:0]                perf_ops,
  output logic [31:0]                perf_stall
`endif
);

  localparam int CNTW = (DP_LAT > 0) ? $clog2(DP_LAT + 1) : 1;
  localparam logic [CNTW-1:0] LAT_LD = CNTW'(DP_LAT);

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr;
  logic [CNTW-1:0]  cnt;

  logic [N_REQ-1:0] pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [IDW-1:0]   ptr_nx;

  logic [DP_IN_W-1:0] lane_data [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign lane_data[gi] = req_data[gi*DP_IN_W +: DP_IN_W];
  end

  rr_pick #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Pointer moves one past the winner, wrapping at N_REQ (not 2^IDW).
  assign ptr_nx = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        // Gated by rst_n: state already reads IDLE while reset is held.
        if (rst_n) req_ready = pick_grant;
        if (pick_any) state_nx = WAIT;
      end
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      dp_in      <= '0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (pick_any) begin
            dp_in   <= lane_data[pick_idx];
            resp_id <= pick_idx;
            cnt     <= LAT_LD;
            rr_ptr  <= ptr_nx;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_data  <= dp_out;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DP_SHARE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else if (state == RESP) begin
      if (resp_ready) perf_ops   <= perf_ops + 32'd1;
      else            perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Bench for dp_share_arbiter: instance A (4 lanes, combinational datapath)
// gets a vector table and a randomized run against a transaction-timeline
// model; instance B (3 lanes, 3-cycle datapath) gets directed sequences
// for latency, non-power-of-two wrap and mid-operation reset.
module tb_dp_share_arbiter;
  import dp_share_pkg::*;

  localparam int NA = 4;
  localparam int LA = 0;
  localparam int NB = 3;
  localparam int LB = 3;
  localparam int IDWA = idw(NA);
  localparam int IDWB = idw(NB);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst_n, b_rst_n;

  // ---------------- instance A ----------------
  logic [NA-1:0]   a_valid, a_ready;
  logic [NA*4-1:0] a_data;
  logic [3:0]      a_dp_in;
  logic [11:0]     a_dp_out, a_rd;
  logic            a_rv, a_rr, a_busy;
  logic [IDWA-1:0] a_id;

  // ---------------- instance B ----------------
  logic [NB-1:0]   b_valid, b_ready;
  logic [NB*4-1:0] b_data;
  logic [3:0]      b_dp_in;
  logic [11:0]     b_dp_out, b_rd;
  logic            b_rv, b_rr, b_busy;
  logic [IDWB-1:0] b_id;

`ifdef DP_SHARE_PERF_EN
  logic [31:0] a_pops, a_pstall, b_pops, b_pstall;
`endif

  // Datapath stubs: A is combinational, B delays the operand LB cycles.
  assign a_dp_out = 12'hA50 | {8'h00, a_dp_in};
  logic [3:0] b_pipe [LB];
  always @(posedge clk) begin
    b_pipe[0] <= b_dp_in;
    for (int i = 1; i < LB; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign b_dp_out = 12'hA50 | {8'h00, b_pipe[LB-1]};

  dp_share_arbiter #(.N_REQ(NA), .DP_LAT(LA)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_data(a_data),
    .req_ready(a_ready), .dp_in(a_dp_in), .dp_out(a_dp_out),
    .resp_valid(a_rv), .resp_ready(a_rr), .resp_data(a_rd), .resp_id(a_id),
    .busy(a_busy)
`ifdef DP_SHARE_PERF_EN
    , .perf_ops(a_pops), .perf_stall(a_pstall)
`endif
  );

  dp_share_arbiter #(.N_REQ(NB), .DP_LAT(LB)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .dp_in(b_dp_in), .dp_out(b_dp_out),
    .resp_valid(b_rv), .resp_ready(b_rr), .resp_data(b_rd), .resp_id(b_id),
    .busy(b_busy)
`ifdef DP_SHARE_PERF_EN
    , .perf_ops(b_pops), .perf_stall(b_pstall)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic        rr;
    logic [3:0]  rdy;
    logic        rv;
    logic [11:0] rd;
    logic [1:0]  id;
    logic        bz;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] v, input logic [15:0] d, input logic rr,
                     input logic [3:0] rdy, input logic rv, input logic [11:0] rd,
                     input logic [1:0] id, input logic bz);
    vec_t t;
    t.valid = v; t.data = d; t.rr = rr; t.rdy = rdy;
    t.rv = rv; t.rd = rd; t.id = id; t.bz = bz;
    tbl.push_back(t);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int first_valid(input logic [NA-1:0] m, input int p);
    logic [IDWA-1:0] ix;
    for (int k = 0; k < NA; k++) begin
      ix = IDWA'((p + k) % NA);
      if (m[ix]) return int'(ix);
    end
    return -1;
  endfunction

  // B: one complete op on a lane with continuous resp_ready.
  task automatic b_op(input int lane, input logic [3:0] val);
    @(negedge clk);
    check($sformatf("b grant lane%0d", lane), 32'(b_ready), 32'(1 << lane));
    check("b idle busy", 32'(b_busy), 0);
    tick();
    for (int w = 0; w < LB + 1; w++) begin
      @(negedge clk);
      check($sformatf("b wait%0d dp_in", w), 32'(b_dp_in), 32'(val));
      check($sformatf("b wait%0d resp_valid", w), 32'(b_rv), 0);
      check($sformatf("b wait%0d busy", w), 32'(b_busy), 1);
      check($sformatf("b wait%0d req_ready", w), 32'(b_ready), 0);
      tick();
    end
    @(negedge clk);
    check("b resp_valid", 32'(b_rv), 1);
    check("b resp_data", 32'(b_rd), 32'(12'hA50 | {8'h00, val}));
    check("b resp_id", 32'(b_id), 32'(lane));
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NA-1:0] v;
    logic [3:0]    ldat [NA];
    int  m_ptr, m_id, m_resp_cyc, g;
    bit  m_active;
    logic [3:0] m_dpin;
    logic [NA-1:0] e_rdy;
    logic e_rv;

    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_valid = '1; a_data = 16'h4321; a_rr = 1'b0;
    b_valid = '1; b_data = 12'h321;  b_rr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a rst req_ready", 32'(a_ready), 0);
    check("a rst resp_valid", 32'(a_rv), 0);
    check("a rst resp_data", 32'(a_rd), 0);
    check("a rst resp_id", 32'(a_id), 0);
    check("a rst busy", 32'(a_busy), 0);
    check("a rst dp_in", 32'(a_dp_in), 0);
    check("b rst req_ready", 32'(b_ready), 0);
    check("b rst busy", 32'(b_busy), 0);
    a_valid = '0; b_valid = '0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();

    // Round robin with all lanes valid: grants 0,1,2,3,0,1 every 3 cycles.
    for (int r = 0; r < 6; r++) begin
      add(4'hF, 16'h4321, 1'b1, 4'(1 << (r % 4)), 1'b0, 12'h000,
          2'((r == 0) ? 0 : (r - 1) % 4), 1'b0);
      add(4'hF, 16'h4321, 1'b1, 4'h0, 1'b0, 12'h000, 2'(r % 4), 1'b1);
      add(4'hF, 16'h4321, 1'b1, 4'h0, 1'b1, 12'hA50 | 12'((r % 4) + 1), 2'(r % 4), 1'b1);
    end
    add(4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 12'h000, 2'd1, 1'b0);
    // Single op on lane 2.
    add(4'h4, 16'h0900, 1'b1, 4'h4, 1'b0, 12'h000, 2'd1, 1'b0);
    add(4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 12'h000, 2'd2, 1'b1);
    add(4'h0, 16'h0000, 1'b1, 4'h0, 1'b1, 12'hA59, 2'd2, 1'b1);
    // Backpressure: lane 3 op, 5 stalled RESP cycles, lane 0 waiting.
    add(4'h8, 16'h7000, 1'b1, 4'h8, 1'b0, 12'h000, 2'd2, 1'b0);
    add(4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 12'h000, 2'd3, 1'b1);
    for (int s = 0; s < 5; s++)
      add(4'h1, 16'h0005, 1'b0, 4'h0, 1'b1, 12'hA57, 2'd3, 1'b1);
    add(4'h1, 16'h0005, 1'b1, 4'h0, 1'b1, 12'hA57, 2'd3, 1'b1);
    add(4'h1, 16'h0005, 1'b1, 4'h1, 1'b0, 12'h000, 2'd3, 1'b0);
    add(4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 12'h000, 2'd0, 1'b1);
    add(4'h0, 16'h0000, 1'b1, 4'h0, 1'b1, 12'hA55, 2'd0, 1'b1);
    add(4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 12'h000, 2'd0, 1'b0);

    foreach (tbl[i]) begin
      a_valid = tbl[i].valid; a_data = tbl[i].data; a_rr = tbl[i].rr;
      @(negedge clk);
      check($sformatf("row%0d req_ready", i), 32'(a_ready), 32'(tbl[i].rdy));
      check($sformatf("row%0d resp_valid", i), 32'(a_rv), 32'(tbl[i].rv));
      check($sformatf("row%0d resp_id", i), 32'(a_id), 32'(tbl[i].id));
      check($sformatf("row%0d busy", i), 32'(a_busy), 32'(tbl[i].bz));
      if (tbl[i].rv)
        check($sformatf("row%0d resp_data", i), 32'(a_rd), 32'(tbl[i].rd));
      tick();
    end
`ifdef DP_SHARE_PERF_EN
    check("a perf_ops", a_pops, 32'd9);
    check("a perf_stall", a_pstall, 32'd5);
`endif

    // Randomized run against a timeline model (fresh reset).
    a_valid = '0; a_rr = 1'b0; a_rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_rst_n = 1'b1;
    tick();
    v = '0;
    for (int l = 0; l < NA; l++) ldat[l] = 4'h0;
    m_ptr = 0; m_id = 0; m_active = 0; m_resp_cyc = 0; m_dpin = 4'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int l = 0; l < NA; l++) begin
        if (v[l]) begin
          if ($urandom_range(0, 15) == 0) v[l] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          v[l] = 1'b1;
          ldat[l] = 4'($urandom_range(0, 15));
        end
        a_data[l*4 +: 4] = ldat[l];
      end
      a_valid = v;
      a_rr = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      e_rv  = m_active && (cyc >= m_resp_cyc);
      e_rdy = '0;
      g = m_active ? -1 : first_valid(v, m_ptr);
      if (g >= 0) e_rdy = NA'(1 << g);
      check("rnd req_ready", 32'(a_ready), 32'(e_rdy));
      check("rnd resp_valid", 32'(a_rv), 32'(e_rv));
      check("rnd busy", 32'(a_busy), 32'(m_active));
      check("rnd resp_id", 32'(a_id), 32'(m_id));
      check("rnd dp_in", 32'(a_dp_in), 32'(m_dpin));
      if (e_rv) check("rnd resp_data", 32'(a_rd), 32'(12'hA50 | {8'h00, m_dpin}));
      // Advance the model across the coming edge.
      if (g >= 0) begin
        m_active   = 1;
        m_resp_cyc = cyc + LA + 2;
        m_id       = g;
        m_dpin     = ldat[IDWA'(g)];
        m_ptr      = (g + 1) % NA;
        v[IDWA'(g)] = 1'b0;
      end else if (e_rv && a_rr) begin
        m_active = 0;
      end
      tick();
    end
    a_valid = '0;

    // B: DP_LAT = 3, lane 1 with operand 6.
    b_rr = 1'b1;
    b_valid = 3'b010; b_data = 12'h060;
    b_op(1, 4'h6);
    // Non-power-of-two wrap: pointer at 2 -> 2, 0, 1, 2.
    b_valid = 3'b111; b_data = 12'h321;
    b_op(2, 4'h3);
    b_op(0, 4'h1);
    b_op(1, 4'h2);
    b_op(2, 4'h3);
    // Mid-op reset: grant lane 0, reset during WAIT.
    b_valid = 3'b001;
    @(negedge clk);
    check("b pre-reset grant", 32'(b_ready), 32'h1);
    tick();
    b_valid = '0;
    @(negedge clk);
    b_rst_n = 1'b0;
    #1;
    check("b midrst busy", 32'(b_busy), 0);
    check("b midrst resp_valid", 32'(b_rv), 0);
    check("b midrst dp_in", 32'(b_dp_in), 0);
    check("b midrst resp_id", 32'(b_id), 0);
    @(negedge clk);
    b_rst_n = 1'b1;
    for (int c = 0; c < LB + 4; c++) begin
      tick();
      @(negedge clk);
      check($sformatf("b postrst%0d resp_valid", c), 32'(b_rv), 0);
      check($sformatf("b postrst%0d busy", c), 32'(b_busy), 0);
    end
    tick();
    b_valid = 3'b111;
    @(negedge clk);
    check("b postrst grant lane0", 32'(b_ready), 32'h1);
    tick();
    b_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
